cosim_commit_tap: RTL and testbench

//  Cosimulation helper for the commit monitor. It contains three independent functions:
//  - delays a decode word by a fixed number of cycles, to align it with commit;
//  - counts retired instructions;
//  - converts a 65-bit HardFloat-recoded FP register value to raw IEEE-754 (DP, or NaN-boxed SP).
//  Non-synthesizable context, but written as synthesizable RTL.

---
 rtl/cosim_commit_tap_pkg.sv | 37 +++
 rtl/cosim_rec_to_raw.sv | 81 ++++++++
 rtl/cosim_commit_tap.sv | 84 ++++++++
 tb/tb_cosim_commit_tap.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/cosim_commit_tap_pkg.sv
// Shared constants and helpers for the commit-monitor cosim tap.
// Covers recoded (HardFloat) field widths, exponent biases and the NaN-box pattern.
package cosim_commit_tap_pkg;

   localparam int dp_exp_w_lp = 12;
   localparam int dp_sig_w_lp = 52;
   localparam int sp_exp_w_lp = 8;
   localparam int sp_sig_w_lp = 23;
   localparam int rec_w_lp    = 1 + dp_exp_w_lp + dp_sig_w_lp;

   localparam logic [dp_exp_w_lp-1:0] dp_norm_bias_lp = 12'd1025;
   localparam logic [dp_exp_w_lp-1:0] dp_sub_bias_lp  = 12'd1026;
   localparam logic [dp_exp_w_lp-1:0] sp_norm_bias_lp = 12'd1921;
   localparam logic [dp_exp_w_lp-1:0] sp_sub_bias_lp  = 12'd1922;

   localparam logic [31:0] nan_box_lp = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      cls_zero_e,
      cls_inf_e,
      cls_nan_e,
      cls_finite_e
   } rec_cls_e;

   // The top three recoded exponent bits select the value class.
   function automatic rec_cls_e classify(input logic [2:0] exp_top);
      rec_cls_e cls;
      case (exp_top)
         3'b000:  cls = cls_zero_e;
         3'b110:  cls = cls_inf_e;
         3'b111:  cls = cls_nan_e;
         default: cls = cls_finite_e;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/cosim_rec_to_raw.sv
// Combinational converter from 65-bit recoded FP to raw IEEE-754.
// SP results are NaN-boxed into the upper 32 bits.
module cosim_rec_to_raw
   import cosim_commit_tap_pkg::*;
(
   input  logic [rec_w_lp-1:0] rec_i,
   input  logic                sp_not_dp_i,
   output logic [63:0]         raw_o
);

   logic                   sign_s;
   logic [dp_exp_w_lp-1:0] exp_s;
   logic [dp_sig_w_lp-1:0] sig_s;
   rec_cls_e               cls_s;

   logic [dp_exp_w_lp-1:0] dp_sub_shift_s;
   logic [dp_exp_w_lp-1:0] sp_sub_shift_s;
   logic [10:0]            dp_norm_exp_s;
   logic [sp_exp_w_lp-1:0] sp_norm_exp_s;
   logic [dp_sig_w_lp-1:0] dp_sub_sig_s;
   logic [sp_sig_w_lp-1:0] sp_sub_sig_s;

   logic [63:0]            dp_raw_s;
   logic [31:0]            sp32_s;

   assign sign_s = rec_i[rec_w_lp-1];
   assign exp_s  = rec_i[rec_w_lp-2 -: dp_exp_w_lp];
   assign sig_s  = rec_i[dp_sig_w_lp-1:0];
   assign cls_s  = classify(exp_s[dp_exp_w_lp-1 -: 3]);

   // Field arithmetic; subnormal shifts are only meaningful below the normal threshold.
   assign dp_sub_shift_s = dp_sub_bias_lp - exp_s;
   assign sp_sub_shift_s = sp_sub_bias_lp - exp_s;
   assign dp_norm_exp_s  = 11'(exp_s - dp_norm_bias_lp);
   assign sp_norm_exp_s  = 8'(exp_s - sp_norm_bias_lp);
   assign dp_sub_sig_s   = 52'({1'b1, sig_s} >> dp_sub_shift_s);
   assign sp_sub_sig_s   = 23'({1'b1, sig_s[dp_sig_w_lp-1 -: sp_sig_w_lp]} >> sp_sub_shift_s);

   // Per-class assembly of both formats, then format select.
   always_comb begin
      dp_raw_s = {sign_s, 63'd0};
      sp32_s   = {sign_s, 31'd0};
      case (cls_s)
         cls_zero_e: begin
            dp_raw_s = {sign_s, 63'd0};
            sp32_s   = {sign_s, 31'd0};
         end
         cls_inf_e: begin
            dp_raw_s = {sign_s, 11'h7FF, 52'd0};
            sp32_s   = {sign_s, 8'hFF, 23'd0};
         end
         cls_nan_e: begin
            dp_raw_s = {sign_s, 11'h7FF, sig_s};
            sp32_s   = {sign_s, 8'hFF, sig_s[dp_sig_w_lp-1 -: sp_sig_w_lp]};
         end
         cls_finite_e: begin
            if (exp_s >= dp_sub_bias_lp) begin
               dp_raw_s = {sign_s, dp_norm_exp_s, sig_s};
            end else begin
               dp_raw_s = {sign_s, 11'd0, dp_sub_sig_s};
            end
            if (exp_s >= sp_sub_bias_lp) begin
               sp32_s = {sign_s, sp_norm_exp_s, sig_s[dp_sig_w_lp-1 -: sp_sig_w_lp]};
            end else begin
               sp32_s = {sign_s, 8'd0, sp_sub_sig_s};
            end
         end
         default: begin
            dp_raw_s = {sign_s, 63'd0};
            sp32_s   = {sign_s, 31'd0};
         end
      endcase

      if (sp_not_dp_i) begin
         raw_o = {nan_box_lp, sp32_s};
      end else begin
         raw_o = dp_raw_s;
      end
   end

endmodule

// File: rtl/cosim_commit_tap.sv
// Cosim tap for the commit monitor: decode-word delay chain, retired-instruction
// counter and recoded-to-raw FP register conversion.
module cosim_commit_tap
   import cosim_commit_tap_pkg::*;
#(
   parameter int width_p      = 32,
   parameter int num_stages_p = 4,
   parameter int max_val_p    = 2**30,
   parameter int init_val_p   = 0
)(
   input  logic                             clk_i,
   input  logic                             reset_i,
   input  logic [width_p-1:0]               data_i,
   output logic [width_p-1:0]               data_o,
   input  logic                             clear_i,
   input  logic                             up_i,
   output logic [$clog2(max_val_p+1)-1:0]   count_o,
   input  logic [rec_w_lp-1:0]              rec_i,
   input  logic                             sp_not_dp_i,
   output logic [63:0]                      raw_o
);

   localparam int cnt_w_lp = $clog2(max_val_p+1);
   localparam logic [cnt_w_lp-1:0] init_lp = cnt_w_lp'(init_val_p);
   localparam logic [cnt_w_lp-1:0] max_lp  = cnt_w_lp'(max_val_p);
   localparam logic [cnt_w_lp-1:0] one_lp  = cnt_w_lp'(1);

   if (num_stages_p == 0) begin : g_wire
      assign data_o = data_i;
   end else begin : g_chain
      logic [width_p-1:0] stage_r [num_stages_p];

      // Free-running shift chain; reset flushes any in-flight words.
      always_ff @(posedge clk_i or negedge reset_i) begin
         if (!reset_i) begin
            for (int i = 0; i < num_stages_p; i++) begin
               stage_r[i] <= {width_p{1'b0}};
            end
         end else begin
            stage_r[0] <= data_i;
            for (int i = 1; i < num_stages_p; i++) begin
               stage_r[i] <= stage_r[i-1];
            end
         end
      end

      assign data_o = stage_r[num_stages_p-1];
   end

   logic [cnt_w_lp-1:0] count_r;
   logic [cnt_w_lp-1:0] count_n_s;

   // Next count: clear wins over hold, and a same-cycle increment still counts.
   always_comb begin
      count_n_s = count_r;
      if (clear_i && up_i) begin
         count_n_s = init_lp + one_lp;
      end else if (clear_i) begin
         count_n_s = init_lp;
      end else if (up_i && (count_r < max_lp)) begin
         count_n_s = count_r + one_lp;
      end else begin
         count_n_s = count_r;
      end
   end

   // Counter state register.
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         count_r <= init_lp;
      end else begin
         count_r <= count_n_s;
      end
   end

   assign count_o = count_r;

   cosim_rec_to_raw u_rec_to_raw (
      .rec_i       (rec_i),
      .sp_not_dp_i (sp_not_dp_i),
      .raw_o       (raw_o)
   );

endmodule

// File: tb/tb_cosim_commit_tap.sv
// Scoreboard bench for cosim_commit_tap: stimulus pushes expected outputs,
// a negedge monitor pops and compares against the live DUT outputs.
module tb_cosim_commit_tap;

   logic        clk;
   logic        reset_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic        clear_i;
   logic        up_i;
   logic [30:0] count_o;
   logic [64:0] rec_i;
   logic        sp_not_dp_i;
   logic [63:0] raw_o;

   logic [31:0] data3_o;
   logic [1:0]  count3_o;
   logic [63:0] raw3_o;

   cosim_commit_tap dut (
      .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .data_o(data_o),
      .clear_i(clear_i), .up_i(up_i), .count_o(count_o),
      .rec_i(rec_i), .sp_not_dp_i(sp_not_dp_i), .raw_o(raw_o)
   );

   cosim_commit_tap #(.max_val_p(3)) dut3 (
      .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .data_o(data3_o),
      .clear_i(clear_i), .up_i(up_i), .count_o(count3_o),
      .rec_i(rec_i), .sp_not_dp_i(sp_not_dp_i), .raw_o(raw3_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [63:0] exp;
   } item_t;

   item_t       sb_q[$];
   int          total = 0;
   int          bad   = 0;

   // Reference model state
   logic [31:0] hist_q[$];
   longint      cnt_m;
   longint      cnt3_m;

   function automatic string item_name(input int id);
      case (id)
         0:       return "data_o";
         1:       return "count_o";
         2:       return "raw_o";
         default: return "count_o_max3";
      endcase
   endfunction

   function automatic logic [63:0] ref_raw(input logic [64:0] rec, input logic sp);
      logic        s;
      int          e;
      logic [51:0] f;
      real         v;
      logic [63:0] b;
      logic [31:0] sp32;
      s = rec[64];
      e = int'(rec[63:52]);
      f = rec[51:0];
      case (rec[63:61])
         3'b000: return sp ? {32'hFFFF_FFFF, s, 31'd0} : {s, 63'd0};
         3'b110: return sp ? {32'hFFFF_FFFF, s, 8'hFF, 23'd0} : {s, 11'h7FF, 52'd0};
         3'b111: return sp ? {32'hFFFF_FFFF, s, 8'hFF, f[51:29]} : {s, 11'h7FF, f};
         default: begin
            if (!sp) begin
               v = (1.0 + real'(f) / (2.0 ** 52)) * (2.0 ** (e - 2048));
               if (s) v = -v;
               return $realtobits(v);
            end
            v = (1.0 + real'(f[51:29]) / (2.0 ** 23)) * (2.0 ** (e - 2048));
            if (v >= 2.0 ** (-126)) begin
               b    = $realtobits(v);
               sp32 = {s, 8'(b[62:52] - 11'd896), b[51:29]};
            end else begin
               sp32 = {s, 8'd0, 23'($rtoi(v * (2.0 ** 149)))};
            end
            return {32'hFFFF_FFFF, sp32};
         end
      endcase
   endfunction

   task automatic reset_model();
      hist_q = {};
      repeat (4) hist_q.push_back(32'd0);
      cnt_m  = 0;
      cnt3_m = 0;
   endtask

   task automatic model_edge();
      if (!reset_i) begin
         reset_model();
      end else begin
         hist_q.push_back(data_i);
         void'(hist_q.pop_front());
         if (clear_i) begin
            cnt_m  = up_i ? 1 : 0;
            cnt3_m = up_i ? 1 : 0;
         end else if (up_i) begin
            cnt_m  = (cnt_m + 1 > 2**30) ? 2**30 : cnt_m + 1;
            cnt3_m = (cnt3_m + 1 > 3) ? 3 : cnt3_m + 1;
         end
      end
   endtask

   // One clock of stimulus; expectations describe the outputs seen until the next edge.
   task automatic step(input logic [31:0] d, input logic cl, input logic up, input logic rs,
                       input logic [64:0] rec, input logic sp,
                       input logic use_const, input logic [63:0] raw_const);
      item_t it;
      @(posedge clk);
      model_edge();
      #1;
      data_i = d; clear_i = cl; up_i = up; reset_i = rs;
      rec_i = rec; sp_not_dp_i = sp;
      if (!rs) reset_model();
      it.id = 0; it.exp = {32'd0, hist_q[0]};                 sb_q.push_back(it);
      it.id = 1; it.exp = 64'(cnt_m);                          sb_q.push_back(it);
      it.id = 3; it.exp = 64'(cnt3_m);                         sb_q.push_back(it);
      it.id = 2; it.exp = use_const ? raw_const : ref_raw(rec, sp); sb_q.push_back(it);
   endtask

   task automatic gen_rec(output logic [64:0] rec, output logic sp);
      logic [63:0] r64;
      logic [51:0] f;
      logic [11:0] e;
      logic        s;
      int          k;
      r64 = {$urandom(), $urandom()};
      f   = r64[51:0];
      s   = 1'($urandom_range(0, 1));
      sp  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 6))
         0: e = {3'b000, 9'($urandom())};
         1: e = {3'b110, 9'($urandom())};
         2: e = {3'b111, 9'($urandom())};
         3: begin e = 12'($urandom_range(1026, 3071)); sp = 1'b0; end
         4: begin
            k  = $urandom_range(1, 52);
            e  = 12'(1026 - k);
            f  = (f >> k) << k;
            sp = 1'b0;
         end
         5: begin e = 12'($urandom_range(1922, 2175)); sp = 1'b1; end
         default: begin e = 12'($urandom_range(1880, 1921)); sp = 1'b1; end
      endcase
      rec = {s, e, f};
   endtask

   // Monitor: drain every pending expectation at the falling edge.
   initial begin
      item_t       it;
      logic [63:0] act;
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            case (it.id)
               0:       act = {32'd0, data_o};
               1:       act = 64'(count_o);
               2:       act = raw_o;
               default: act = 64'(count3_o);
            endcase
            total++;
            if (act !== it.exp) begin
               bad++;
               $display("FAIL %s: got %h want %h", item_name(it.id), act, it.exp);
            end
         end
      end
   end

   initial begin
      logic [64:0] rec;
      logic        sp;
      logic [64:0] one_dp;
      one_dp = {1'b0, 12'h800, 52'd0};
      reset_i = 1'b0; data_i = 32'd0; clear_i = 1'b0; up_i = 1'b0;
      rec_i = 65'd0; sp_not_dp_i = 1'b0;
      reset_model();

      repeat (3) step(32'd0, 1'b0, 1'b0, 1'b0, one_dp, 1'b0, 1'b1, 64'h3FF0_0000_0000_0000);

      for (int i = 1; i <= 12; i++)
         step(32'(i), 1'b0, 1'b0, 1'b1, one_dp, 1'b0, 1'b0, 64'd0);
      step(32'd13, 1'b0, 1'b0, 1'b0, one_dp, 1'b0, 1'b0, 64'd0);
      for (int i = 14; i <= 20; i++)
         step(32'(i), 1'b0, 1'b0, 1'b1, one_dp, 1'b0, 1'b0, 64'd0);

      repeat (5) step(32'd0, 1'b0, 1'b1, 1'b1, one_dp, 1'b0, 1'b0, 64'd0);
      step(32'd0, 1'b0, 1'b0, 1'b1, one_dp, 1'b0, 1'b0, 64'd0);
      step(32'd0, 1'b1, 1'b1, 1'b1, one_dp, 1'b0, 1'b0, 64'd0);
      step(32'd0, 1'b1, 1'b0, 1'b1, one_dp, 1'b0, 1'b0, 64'd0);
      repeat (10) step(32'd0, 1'b0, 1'b1, 1'b1, one_dp, 1'b0, 1'b0, 64'd0);
      step(32'd0, 1'b0, 1'b0, 1'b1, one_dp, 1'b0, 1'b0, 64'd0);

      step(32'd0, 1'b0, 1'b0, 1'b1, one_dp, 1'b0, 1'b1, 64'h3FF0_0000_0000_0000);
      step(32'd0, 1'b0, 1'b0, 1'b1, {1'b1, 12'h000, 52'd0}, 1'b0, 1'b1, 64'h8000_0000_0000_0000);
      step(32'd0, 1'b0, 1'b0, 1'b1, {1'b0, 12'hC00, 52'd0}, 1'b0, 1'b1, 64'h7FF0_0000_0000_0000);
      step(32'd0, 1'b0, 1'b0, 1'b1, {1'b1, 12'hE00, 52'd1}, 1'b0, 1'b1, 64'hFFF0_0000_0000_0001);
      step(32'd0, 1'b0, 1'b0, 1'b1, {1'b0, 12'd1025, 52'd0}, 1'b0, 1'b1, 64'h0008_0000_0000_0000);
      step(32'd0, 1'b0, 1'b0, 1'b1, one_dp, 1'b1, 1'b1, 64'hFFFF_FFFF_3F80_0000);
      step(32'd0, 1'b0, 1'b0, 1'b1, {1'b1, 12'h801, 52'd0}, 1'b1, 1'b1, 64'hFFFF_FFFF_C000_0000);
      step(32'd0, 1'b0, 1'b0, 1'b1, {1'b0, 12'hE00, 52'h8_0000_0000_0000}, 1'b1, 1'b1, 64'hFFFF_FFFF_7FC0_0000);
      step(32'd0, 1'b0, 1'b0, 1'b1, {1'b0, 12'd1921, 52'd0}, 1'b1, 1'b1, 64'hFFFF_FFFF_0040_0000);
      step(32'd0, 1'b0, 1'b0, 1'b1, {1'b1, 12'd1892, 52'd0}, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000);

      for (int n = 0; n < 400; n++) begin
         gen_rec(rec, sp);
         step($urandom(), 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 49) != 0), rec, sp, 1'b0, 64'd0);
      end

      repeat (2) @(negedge clk);
      #1;
      total++;
      if (sb_q.size() != 0) begin
         bad++;
         $display("FAIL drain: got %0d pending want 0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
